// File: rtl/img_pkg.sv
// Shared image-pipeline types and widths used by the mosaic encoder, the demosaic
// block and the bench interface.
package img_pkg;

  localparam int unsigned PIX_DW = 12;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [1:0] {
    RGGB = 2'd0,
    GRBG = 2'd1,
    GBRG = 2'd2,
    BGGR = 2'd3
  } bayer_pat_e;

  typedef enum logic {
    WAIT_SOF = 1'b0,
    ACTIVE   = 1'b1
  } mosaic_state_e;

endpackage

// File: rtl/bayer_phase_sel.sv
// Combinational Bayer component picker: selects R, G or B from the 2x2 tile phase
// {y[0], x[0]} and the colour order of the tile.
module bayer_phase_sel
  import img_pkg::*;
#(
  parameter int unsigned DW = PIX_DW
) (
  input  logic [1:0]    i_phase,
  input  bayer_pat_e    i_pat,
  input  logic [DW-1:0] i_red,
  input  logic [DW-1:0] i_green,
  input  logic [DW-1:0] i_blue,
  output logic [DW-1:0] o_data
);

  typedef enum logic [1:0] {SelR, SelG, SelB} sel_e;

  sel_e w_sel;

  always_comb begin
    w_sel = SelG;
    unique case (i_pat)
      RGGB: begin
        if (i_phase == 2'b00) w_sel = SelR;
        if (i_phase == 2'b11) w_sel = SelB;
      end
      GRBG: begin
        if (i_phase == 2'b01) w_sel = SelR;
        if (i_phase == 2'b10) w_sel = SelB;
      end
      GBRG: begin
        if (i_phase == 2'b01) w_sel = SelB;
        if (i_phase == 2'b10) w_sel = SelR;
      end
      BGGR: begin
        if (i_phase == 2'b00) w_sel = SelB;
        if (i_phase == 2'b11) w_sel = SelR;
      end
      default: w_sel = SelG;
    endcase
  end

  always_comb begin
    o_data = i_green;
    unique case (w_sel)
      SelR:    o_data = i_red;
      SelB:    o_data = i_blue;
      default: o_data = i_green;
    endcase
  end

endmodule

// File: rtl/bayer_mosaic.sv
// RGB-to-Bayer mosaic encoder: frames the incoming pixel stream on i_sof, tracks
// pixel coordinates and emits one registered Bayer sample per accepted pixel.
module bayer_mosaic
  import img_pkg::*;
#(
  parameter int unsigned IMG_W     = 640,
  parameter int unsigned IMG_H     = 480,
  parameter int unsigned DW        = PIX_DW,
  parameter int unsigned CW        = CNT_W,
  parameter int unsigned BAYER_PAT = 0
) (
  input  logic          p_clk,
  input  logic          rst,
  input  logic [DW-1:0] i_red,
  input  logic [DW-1:0] i_green,
  input  logic [DW-1:0] i_blue,
  input  logic          i_data_val,
  input  logic          i_sof,
  output logic [DW-1:0] o_data,
  output logic          o_data_val,
  output logic [CW-1:0] o_X_cnt,
  output logic [CW-1:0] o_Y_cnt,
  output logic          o_eol,
  output logic          o_eof,
  output logic          o_short_frame
);

  if ((IMG_W % 2) != 0 || (IMG_H % 2) != 0) begin : g_bad_size
    $error("bayer_mosaic: IMG_W and IMG_H must be even");
  end
  if (64'(IMG_W) > (64'd1 << CW) || 64'(IMG_H) > (64'd1 << CW)) begin : g_bad_cw
    $error("bayer_mosaic: IMG_W/IMG_H exceed counter range 2**CW");
  end
  if (BAYER_PAT > 3) begin : g_bad_pat
    $error("bayer_mosaic: BAYER_PAT must be in 0..3");
  end

  localparam bayer_pat_e PAT = bayer_pat_e'(BAYER_PAT[1:0]);

  mosaic_state_e r_state, w_state_nxt;

  logic [CW-1:0] r_x, r_y, w_x_nxt, w_y_nxt;
  logic [CW-1:0] w_x_cur, w_y_cur;
  logic          w_accept, w_restart, w_eol, w_last;
  logic [DW-1:0] w_sample;

  logic [DW-1:0] r_data;
  logic          r_data_val;
  logic [CW-1:0] r_x_out, r_y_out;
  logic          r_eol, r_eof, r_short;

  // A sof pixel always lands on (0,0), whatever the counters held.
  assign w_x_cur = i_sof ? '0 : r_x;
  assign w_y_cur = i_sof ? '0 : r_y;
  assign w_eol   = (w_x_cur == CW'(IMG_W - 1));
  assign w_last  = w_eol && (w_y_cur == CW'(IMG_H - 1));

  always_ff @(posedge p_clk) begin
    if (rst) begin
      r_state <= WAIT_SOF;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_accept) begin
      w_state_nxt = w_last ? WAIT_SOF : ACTIVE;
    end
  end

  always_comb begin
    w_accept  = 1'b0;
    w_restart = 1'b0;
    unique case (r_state)
      WAIT_SOF: w_accept = i_data_val && i_sof;
      ACTIVE: begin
        w_accept  = i_data_val;
        w_restart = i_data_val && i_sof;
      end
      default: begin
        w_accept  = 1'b0;
        w_restart = 1'b0;
      end
    endcase
  end

  always_comb begin
    w_x_nxt = r_x;
    w_y_nxt = r_y;
    if (w_accept) begin
      if (w_last) begin
        w_x_nxt = '0;
        w_y_nxt = '0;
      end else if (w_eol) begin
        w_x_nxt = '0;
        w_y_nxt = w_y_cur + CW'(1);
      end else begin
        w_x_nxt = w_x_cur + CW'(1);
        w_y_nxt = w_y_cur;
      end
    end
  end

  always_ff @(posedge p_clk) begin
    if (rst) begin
      r_x <= '0;
      r_y <= '0;
    end else begin
      r_x <= w_x_nxt;
      r_y <= w_y_nxt;
    end
  end

  bayer_phase_sel #(
    .DW (DW)
  ) u_phase_sel (
    .i_phase ({w_y_cur[0], w_x_cur[0]}),
    .i_pat   (PAT),
    .i_red   (i_red),
    .i_green (i_green),
    .i_blue  (i_blue),
    .o_data  (w_sample)
  );

  // Sample and coordinates hold across idle cycles; pulses are qualified by accept.
  always_ff @(posedge p_clk) begin
    if (rst) begin
      r_data     <= '0;
      r_data_val <= 1'b0;
      r_x_out    <= '0;
      r_y_out    <= '0;
      r_eol      <= 1'b0;
      r_eof      <= 1'b0;
      r_short    <= 1'b0;
    end else begin
      r_data_val <= w_accept;
      r_eol      <= w_accept && w_eol;
      r_eof      <= w_accept && w_last;
      r_short    <= w_restart;
      if (w_accept) begin
        r_data  <= w_sample;
        r_x_out <= w_x_cur;
        r_y_out <= w_y_cur;
      end
    end
  end

  assign o_data        = r_data;
  assign o_data_val    = r_data_val;
  assign o_X_cnt       = r_x_out;
  assign o_Y_cnt       = r_y_out;
  assign o_eol         = r_eol;
  assign o_eof         = r_eof;
  assign o_short_frame = r_short;

endmodule

// File: tb/tb_bayer_mosaic.sv
// Bench for bayer_mosaic: four instances (one per colour order) on a 4x2 image share
// stimulus; a behavioural model feeds a scoreboard queue, plus a fixed vector table.
module tb_bayer_mosaic;

  localparam int W = 4;
  localparam int H = 2;

  logic        p_clk;
  logic        rst;
  logic [11:0] i_red, i_green, i_blue;
  logic        i_data_val, i_sof;

  logic [11:0] o_data        [4];
  logic        o_data_val    [4];
  logic [15:0] o_X_cnt       [4];
  logic [15:0] o_Y_cnt       [4];
  logic        o_eol         [4];
  logic        o_eof         [4];
  logic        o_short_frame [4];

  for (genvar p = 0; p < 4; p++) begin : g_dut
    bayer_mosaic #(
      .IMG_W     (W),
      .IMG_H     (H),
      .DW        (12),
      .CW        (16),
      .BAYER_PAT (p)
    ) u_dut (
      .p_clk         (p_clk),
      .rst           (rst),
      .i_red         (i_red),
      .i_green       (i_green),
      .i_blue        (i_blue),
      .i_data_val    (i_data_val),
      .i_sof         (i_sof),
      .o_data        (o_data[p]),
      .o_data_val    (o_data_val[p]),
      .o_X_cnt       (o_X_cnt[p]),
      .o_Y_cnt       (o_Y_cnt[p]),
      .o_eol         (o_eol[p]),
      .o_eof         (o_eof[p]),
      .o_short_frame (o_short_frame[p])
    );
  end

  initial p_clk = 1'b0;
  always #5 p_clk = ~p_clk;

  typedef struct packed {
    logic [3:0][11:0] d;
    logic [15:0]      x;
    logic [15:0]      y;
    logic             eol;
    logic             eof;
    logic             shrt;
  } exp_t;

  typedef struct {
    logic        sof;
    logic [11:0] r, g, b;
    logic [11:0] d0, d1, d2, d3;
    int          x, y;
    logic        eol, eof;
  } vec_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_err    = 0;
  logic        m_active = 1'b0;
  int          m_x      = 0;
  int          m_y      = 0;
  exp_t        held     = '0;
  vec_t        tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] comp(input int pat, input int x, input int y,
                                       input logic [11:0] r, g, b);
    logic [1:0] ph;
    ph = {y[0], x[0]};
    case (pat)
      0: return (ph == 2'b00) ? r : (ph == 2'b11) ? b : g;
      1: return (ph == 2'b01) ? r : (ph == 2'b10) ? b : g;
      2: return (ph == 2'b01) ? b : (ph == 2'b10) ? r : g;
      default: return (ph == 2'b00) ? b : (ph == 2'b11) ? r : g;
    endcase
  endfunction

  // One clock: drive inputs, update model/scoreboard, then check all instances.
  task automatic cycle(input logic rst_v, input logic val, input logic sof,
                       input logic [11:0] r, input logic [11:0] g, input logic [11:0] b);
    exp_t e;
    logic acc;
    int   x, y;
    rst = rst_v; i_data_val = val; i_sof = sof;
    i_red = r; i_green = g; i_blue = b;
    acc = 1'b0;
    e   = '0;
    if (rst_v) begin
      m_active = 1'b0; m_x = 0; m_y = 0;
    end else if (val && (m_active || sof)) begin
      x = sof ? 0 : m_x;
      y = sof ? 0 : m_y;
      e.x = 16'(x); e.y = 16'(y);
      e.eol  = (x == W - 1);
      e.eof  = e.eol && (y == H - 1);
      e.shrt = sof && m_active;
      for (int p = 0; p < 4; p++) e.d[p] = comp(p, x, y, r, g, b);
      sb.push_back(e);
      acc = 1'b1;
      if (e.eof) begin
        m_active = 1'b0; m_x = 0; m_y = 0;
      end else begin
        m_active = 1'b1;
        if (e.eol) begin m_x = 0; m_y = y + 1; end
        else begin m_x = x + 1; m_y = y; end
      end
    end
    @(posedge p_clk);
    #1;
    if (rst_v) held = '0;
    for (int p = 0; p < 4; p++) chk($sformatf("data_val[%0d]", p), 32'(o_data_val[p]), 32'(acc));
    if (acc) begin
      if (sb.size() == 0) begin
        chk("scoreboard_empty", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        held = e;
      end
    end
    if (!acc) begin
      held.eol = 1'b0; held.eof = 1'b0; held.shrt = 1'b0;
    end
    for (int p = 0; p < 4; p++) begin
      chk($sformatf("data[%0d]", p), 32'(o_data[p]), 32'(held.d[p]));
      chk($sformatf("x[%0d]", p), 32'(o_X_cnt[p]), 32'(held.x));
      chk($sformatf("y[%0d]", p), 32'(o_Y_cnt[p]), 32'(held.y));
      chk($sformatf("eol[%0d]", p), 32'(o_eol[p]), 32'(held.eol));
      chk($sformatf("eof[%0d]", p), 32'(o_eof[p]), 32'(held.eof));
      chk($sformatf("short[%0d]", p), 32'(o_short_frame[p]), 32'(held.shrt));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 12'h0, 12'h0, 12'h0);
  endtask

  task automatic rnd_px(input logic sof);
    cycle(1'b0, 1'b1, sof, 12'($urandom_range(4095)), 12'($urandom_range(4095)),
          12'($urandom_range(4095)));
  endtask

  task automatic run_table;
    for (int k = 0; k < 8; k++) begin
      cycle(1'b0, 1'b1, tbl[k].sof, tbl[k].r, tbl[k].g, tbl[k].b);
      chk($sformatf("tbl%0d_rggb", k), 32'(o_data[0]), 32'(tbl[k].d0));
      chk($sformatf("tbl%0d_grbg", k), 32'(o_data[1]), 32'(tbl[k].d1));
      chk($sformatf("tbl%0d_gbrg", k), 32'(o_data[2]), 32'(tbl[k].d2));
      chk($sformatf("tbl%0d_bggr", k), 32'(o_data[3]), 32'(tbl[k].d3));
      chk($sformatf("tbl%0d_x", k), 32'(o_X_cnt[0]), 32'(tbl[k].x));
      chk($sformatf("tbl%0d_y", k), 32'(o_Y_cnt[0]), 32'(tbl[k].y));
      chk($sformatf("tbl%0d_eol", k), 32'(o_eol[0]), 32'(tbl[k].eol));
      chk($sformatf("tbl%0d_eof", k), 32'(o_eof[0]), 32'(tbl[k].eof));
    end
  endtask

  initial begin
    tbl[0] = '{1'b1, 12'h100, 12'h200, 12'h300, 12'h100, 12'h200, 12'h200, 12'h300, 0, 0, 0, 0};
    tbl[1] = '{1'b0, 12'h101, 12'h201, 12'h301, 12'h201, 12'h101, 12'h301, 12'h201, 1, 0, 0, 0};
    tbl[2] = '{1'b0, 12'h102, 12'h202, 12'h302, 12'h102, 12'h202, 12'h202, 12'h302, 2, 0, 0, 0};
    tbl[3] = '{1'b0, 12'h103, 12'h203, 12'h303, 12'h203, 12'h103, 12'h303, 12'h203, 3, 0, 1, 0};
    tbl[4] = '{1'b0, 12'h104, 12'h204, 12'h304, 12'h204, 12'h304, 12'h104, 12'h204, 0, 1, 0, 0};
    tbl[5] = '{1'b0, 12'h105, 12'h205, 12'h305, 12'h305, 12'h205, 12'h205, 12'h105, 1, 1, 0, 0};
    tbl[6] = '{1'b0, 12'h106, 12'h206, 12'h306, 12'h206, 12'h306, 12'h106, 12'h206, 2, 1, 0, 0};
    tbl[7] = '{1'b0, 12'h107, 12'h207, 12'h307, 12'h307, 12'h207, 12'h207, 12'h107, 3, 1, 1, 1};

    // Reset, then the basic frame for all four colour orders.
    cycle(1'b1, 1'b0, 1'b0, 12'h0, 12'h0, 12'h0);
    cycle(1'b1, 1'b0, 1'b0, 12'h0, 12'h0, 12'h0);
    run_table();
    idle(2);

    // Pixels without sof are dropped until a frame starts.
    for (int i = 0; i < 3; i++) rnd_px(1'b0);
    rnd_px(1'b1);
    for (int i = 0; i < 7; i++) rnd_px(1'b0);
    idle(1);

    // Idle gaps of 1, 2 and 5 cycles mid-line and between lines.
    for (int k = 0; k < 8; k++) begin
      cycle(1'b0, 1'b1, tbl[k].sof, tbl[k].r, tbl[k].g, tbl[k].b);
      if (k == 1) idle(1);
      if (k == 3) idle(2);
      if (k == 5) idle(5);
    end
    idle(1);

    // Restart after 5 pixels, and a restart immediately after (0,0).
    for (int i = 0; i < 5; i++) rnd_px(i == 0);
    rnd_px(1'b1);
    rnd_px(1'b1);
    for (int i = 0; i < 7; i++) rnd_px(1'b0);
    idle(1);

    // Reset mid-frame on the third pixel.
    rnd_px(1'b1);
    rnd_px(1'b0);
    cycle(1'b1, 1'b1, 1'b0, 12'h123, 12'h456, 12'h789);
    rnd_px(1'b0);
    rnd_px(1'b0);
    run_table();
    idle(2);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
